zsdram_port_arbiter: RTL and testbench

- Three-client arbiter in front of the SDRAM word-access controller.
- Clients: ch0 = photon capture writer, ch1 = TFT display reader, ch2 = host readout reader.
- Round-robin arbitration grants one client at a time and drives the controller's 2-bit write/read request. It holds that request until the controller's matching done pulse, then returns read data and a per-client done pulse.
- Refresh and initial sequencing stay inside the controller; the arbiter simply waits through them.

---
 rtl/zsdram_port_arbiter_if.sv | 34 +++
 rtl/zsdram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_zsdram_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/zsdram_port_arbiter_if.sv
// Bus bundle between the three SDRAM clients, the port arbiter and the
// SDRAM word-access controller.
// slave  : arbiter side (consumes client requests and controller status).
// master : environment side (clients plus controller).
interface zsdram_port_arbiter_if #(
   parameter int AW = 22,
   parameter int DW = 16
);
   logic [2:0]      ch_req;
   logic [2:0]      ch_wr;
   logic [3*AW-1:0] ch_addr;
   logic [3*DW-1:0] ch_wdata;
   logic [2:0]      ch_grant;
   logic [2:0]      ch_done;
   logic [DW-1:0]   ch_rdata;
   logic [1:0]      sdram_req;
   logic [1:0]      sdram_done;
   logic [AW-1:0]   sdram_addr;
   logic [DW-1:0]   sdram_wdata;
   logic [DW-1:0]   sdram_rdata;
   logic            arb_err;

   modport slave (
      input  ch_req, ch_wr, ch_addr, ch_wdata, sdram_done, sdram_rdata,
      output ch_grant, ch_done, ch_rdata, sdram_req, sdram_addr, sdram_wdata,
             arb_err
   );

   modport master (
      output ch_req, ch_wr, ch_addr, ch_wdata, sdram_done, sdram_rdata,
      input  ch_grant, ch_done, ch_rdata, sdram_req, sdram_addr, sdram_wdata,
             arb_err
   );
endinterface

// File: rtl/zsdram_port_arbiter.sv
// Round-robin arbiter for three SDRAM clients (ch0 capture writer,
// ch1 TFT reader, ch2 host reader) in front of the word-access controller.
// Optional busy watchdog: define ZSDRAM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; grant the next requester in round-robin order
// BUSY  | request held to controller until the matching done bit
// GAP   | one cycle to clear grant/done before the next arbitration
module zsdram_port_arbiter #(
   parameter int AW      = 22,
   parameter int DW      = 16,
   parameter int TIMEOUT = 2047
) (
   input logic               clk,
   input logic               rst_n,
   zsdram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    rr_q, rr_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    done_q, done_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    c1, c2, win;
   logic          match;

`ifdef ZSDRAM_ARB_TIMEOUT_EN
   localparam logic [10:0] WD_LIMIT = 11'(TIMEOUT - 1);
   logic [10:0] wd_q, wd_d;
   logic        err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^11'(TIMEOUT);
`endif

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Round-robin search order rr+1, rr+2, rr; direction-matched done detect.
   always_comb begin
      c1    = nxt(rr_q);
      c2    = nxt(c1);
      win   = rr_q;
      if (bus.ch_req[c1])
         win = c1;
      else if (bus.ch_req[c2])
         win = c2;
      match = req_q[1] ? bus.sdram_done[1] : bus.sdram_done[0];
   end

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      done_d  = done_q;
      rdata_d = rdata_q;
      req_d   = req_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef ZSDRAM_ARB_TIMEOUT_EN
      wd_d    = wd_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.ch_req) begin
               grant_d = 3'b001 << win;
               req_d   = bus.ch_wr[win] ? 2'b10 : 2'b01;
               addr_d  = bus.ch_addr[win*AW +: AW];
               wdata_d = bus.ch_wdata[win*DW +: DW];
               rr_d    = win;
               state_d = BUSY;
`ifdef ZSDRAM_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         BUSY: begin
`ifdef ZSDRAM_ARB_TIMEOUT_EN
            wd_d = wd_q + 11'd1;
`endif
            // Dropping the request here lands before the controller's idle
            // step, so it never sees the same request twice.
            if (match) begin
               req_d   = 2'b00;
               done_d  = grant_q;
               if (req_q[0])
                  rdata_d = bus.sdram_rdata;
               state_d = GAP;
            end
`ifdef ZSDRAM_ARB_TIMEOUT_EN
            else if (wd_q == WD_LIMIT) begin
               req_d   = 2'b00;
               done_d  = grant_q;
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = GAP;
            end
`endif
         end
         GAP: begin
            done_d  = 3'b000;
            grant_d = 3'b000;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; rr starts at 2 so ch0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= 2'd2;
         grant_q <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         req_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef ZSDRAM_ARB_TIMEOUT_EN
   // Busy watchdog and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
   assign bus.arb_err = err_q;
`else
   assign bus.arb_err = 1'b0;
`endif

   assign bus.ch_grant    = grant_q;
   assign bus.ch_done     = done_q;
   assign bus.ch_rdata    = rdata_q;
   assign bus.sdram_req   = req_q;
   assign bus.sdram_addr  = addr_q;
   assign bus.sdram_wdata = wdata_q;

endmodule

// File: tb/tb_zsdram_port_arbiter.sv
// Directed self-checking bench for zsdram_port_arbiter.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_zsdram_port_arbiter;
   localparam int AW = 22;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   zsdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   zsdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_grant"}, 32'(bus.ch_grant), 32'h0);
      check({tag, "_done"},  32'(bus.ch_done), 32'h0);
      check({tag, "_req"},   32'(bus.sdram_req), 32'h0);
   endtask

   initial begin
      logic [1:0] w;
      bus.ch_req      = 3'b000;
      bus.ch_wr       = 3'b000;
      bus.ch_addr     = '0;
      bus.ch_wdata    = '0;
      bus.sdram_done  = 2'b00;
      bus.sdram_rdata = '0;

      // Reset values
      tick();
      tick();
      check_idle_outputs("rst");
      check("rst_addr",  32'(bus.sdram_addr), 32'h0);
      check("rst_wdata", 32'(bus.sdram_wdata), 32'h0);
      check("rst_rdata", 32'(bus.ch_rdata), 32'h0);
      check("rst_err",   32'(bus.arb_err), 32'h0);
      rst_n = 1'b1;
      tick();

      // ch0 write 0x000123 <- 0xBEEF
      bus.ch_req = 3'b001;
      bus.ch_wr  = 3'b001;
      bus.ch_addr[0*AW +: AW]  = 22'h000123;
      bus.ch_wdata[0*DW +: DW] = 16'hBEEF;
      tick();
      check("w0_req",   32'(bus.sdram_req), 32'h2);
      check("w0_grant", 32'(bus.ch_grant), 32'h1);
      check("w0_addr",  32'(bus.sdram_addr), 32'h000123);
      check("w0_wdata", 32'(bus.sdram_wdata), 32'hBEEF);
      // client drops request and changes its bus fields mid-transaction
      bus.ch_req = 3'b000;
      bus.ch_addr[0*AW +: AW]  = 22'h3FFFFF;
      bus.ch_wdata[0*DW +: DW] = 16'h0000;
      bus.ch_wr  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("w0_hold_req",  32'(bus.sdram_req), 32'h2);
         check("w0_hold_done", 32'(bus.ch_done), 32'h0);
      end
      check("w0_hold_addr",  32'(bus.sdram_addr), 32'h000123);
      check("w0_hold_wdata", 32'(bus.sdram_wdata), 32'hBEEF);
      bus.sdram_done = 2'b10;
      tick();
      bus.sdram_done = 2'b00;
      check("w0_done",     32'(bus.ch_done), 32'h1);
      check("w0_req_drop", 32'(bus.sdram_req), 32'h0);
      tick();
      check_idle_outputs("w0_gap");
      tick();

      // ch1 read 0x0000FF -> 0x5A5A
      bus.ch_req = 3'b010;
      bus.ch_wr  = 3'b000;
      bus.ch_addr[1*AW +: AW] = 22'h0000FF;
      tick();
      bus.ch_req = 3'b000;
      check("r1_grant", 32'(bus.ch_grant), 32'h2);
      check("r1_req",   32'(bus.sdram_req), 32'h1);
      check("r1_addr",  32'(bus.sdram_addr), 32'h0000FF);
      tick();
      check("r1_busy_req", 32'(bus.sdram_req), 32'h1);
      bus.sdram_rdata = 16'h5A5A;
      bus.sdram_done  = 2'b01;
      tick();
      bus.sdram_done  = 2'b00;
      bus.sdram_rdata = 16'h0000;
      check("r1_done",  32'(bus.ch_done), 32'h2);
      check("r1_rdata", 32'(bus.ch_rdata), 32'h5A5A);
      check("r1_req0",  32'(bus.sdram_req), 32'h0);
      tick();
      check_idle_outputs("r1_gap");
      check("r1_rdata_hold", 32'(bus.ch_rdata), 32'h5A5A);
      tick();

      // ch2 read, wrong done bit ignored
      bus.ch_req = 3'b100;
      bus.ch_addr[2*AW +: AW] = 22'h0003AB;
      tick();
      bus.ch_req = 3'b000;
      check("r2_grant", 32'(bus.ch_grant), 32'h4);
      check("r2_req",   32'(bus.sdram_req), 32'h1);
      bus.sdram_rdata = 16'h1111;
      bus.sdram_done  = 2'b10;
      tick();
      check("r2_wrongbit_done", 32'(bus.ch_done), 32'h0);
      check("r2_wrongbit_req",  32'(bus.sdram_req), 32'h1);
      bus.sdram_rdata = 16'h7E7E;
      bus.sdram_done  = 2'b01;
      tick();
      bus.sdram_done  = 2'b00;
      check("r2_done",  32'(bus.ch_done), 32'h4);
      check("r2_rdata", 32'(bus.ch_rdata), 32'h7E7E);
      tick();
      check_idle_outputs("r2_gap");
      tick();

      // All three request continuously: grants rotate 0,1,2,0,1,2
      bus.ch_req = 3'b111;
      bus.ch_wr  = 3'b000;
      bus.ch_addr = {22'h000C02, 22'h000C01, 22'h000C00};
      for (int t = 0; t < 6; t++) begin
         w = 2'(t % 3);
         tick();
         check("rr_grant", 32'(bus.ch_grant), 32'(3'b001 << w));
         check("rr_addr",  32'(bus.sdram_addr), 32'h000C00 + 32'(w));
         check("rr_req",   32'(bus.sdram_req), 32'h1);
         bus.sdram_rdata = 16'hA000 + 16'(t);
         bus.sdram_done  = 2'b01;
         tick();
         bus.sdram_done  = 2'b00;
         check("rr_done",  32'(bus.ch_done), 32'(3'b001 << w));
         check("rr_rdata", 32'(bus.ch_rdata), 32'hA000 + 32'(t));
         tick();
         check_idle_outputs("rr_gap");
      end

      // Reset 2 cycles into BUSY; ch0 and ch1 both requesting
      bus.ch_req = 3'b011;
      bus.ch_wr  = 3'b011;
      tick();
      check("rs_grant", 32'(bus.ch_grant), 32'h1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rs_async");
      check("rs_addr", 32'(bus.sdram_addr), 32'h0);
      check("rs_rdata", 32'(bus.ch_rdata), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rs_regrant", 32'(bus.ch_grant), 32'h1);
      check("rs_req",     32'(bus.sdram_req), 32'h2);
      bus.ch_req = 3'b000;
      bus.sdram_done = 2'b10;
      tick();
      bus.sdram_done = 2'b00;
      check("rs_done", 32'(bus.ch_done), 32'h1);
      tick();
      tick();

`ifdef ZSDRAM_ARB_TIMEOUT_EN
      // Watchdog: controller never answers a ch2 read
      bus.ch_req = 3'b100;
      bus.ch_wr  = 3'b000;
      bus.sdram_rdata = 16'hDEAD;
      tick();
      bus.ch_req = 3'b000;
      check("to_grant", 32'(bus.ch_grant), 32'h4);
      for (int i = 0; i < 15; i++) tick();
      check("to_req_before", 32'(bus.sdram_req), 32'h1);
      check("to_err_before", 32'(bus.arb_err), 32'h0);
      tick();
      check("to_req",   32'(bus.sdram_req), 32'h0);
      check("to_err",   32'(bus.arb_err), 32'h1);
      check("to_done",  32'(bus.ch_done), 32'h4);
      check("to_rdata", 32'(bus.ch_rdata), 32'h0);
      tick();
      check("to_single_done", 32'(bus.ch_done), 32'h0);
      tick();
      bus.ch_req = 3'b001;
      bus.ch_wr  = 3'b001;
      tick();
      bus.ch_req = 3'b000;
      bus.sdram_done = 2'b10;
      tick();
      bus.sdram_done = 2'b00;
      check("to_good_done", 32'(bus.ch_done), 32'h1);
      check("to_err_sticky", 32'(bus.arb_err), 32'h1);
      tick();
      tick();
`else
      check("err_tied_low", 32'(bus.arb_err), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
